// File: rtl/altr_hps_rr_arb2_if.sv
// altr_hps_rr_arb2_if -- handshake bundle between two requestors, the shared
// resource and the round-robin arbiter.
//   req_in1/req_in2 : level requests, held until served
//   done_in         : single-cycle completion pulse from the resource
//   gnt_out1/2      : registered one-hot grants
//   busy_out        : arbiter is not idle
//   last_out        : last winner (0 = requestor 1, 1 = requestor 2)
//   timeout_out     : one-cycle pulse when a grant is pulled without done_in
// slave is the arbiter side; master is the requestor/resource side.
interface altr_hps_rr_arb2_if;
  logic req_in1;
  logic req_in2;
  logic done_in;
  logic gnt_out1;
  logic gnt_out2;
  logic busy_out;
  logic last_out;
  logic timeout_out;

  modport slave (
    input  req_in1, req_in2, done_in,
    output gnt_out1, gnt_out2, busy_out, last_out, timeout_out
  );

  modport master (
    output req_in1, req_in2, done_in,
    input  gnt_out1, gnt_out2, busy_out, last_out, timeout_out
  );
endinterface

// File: rtl/altr_hps_rr_arb2.sv
// altr_hps_rr_arb2 -- two-requestor round-robin arbiter for a shared resource.
// Grants are held until the resource pulses done_in or, when TO_EN is set, until
// the grant has been high for 2^TO_W cycles. Each grant is followed by a one-cycle
// RELEASE state before the arbiter returns to IDLE.
// Ports:
//   clk   : block clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : altr_hps_rr_arb2_if.slave (requests, done, grants, status)
// Parameters:
//   TO_W  : grant timeout counter width (2..16)
//   TO_EN : 1 enables the grant timeout, 0 disables it
module altr_hps_rr_arb2 #(
  parameter int TO_W  = 8,
  parameter int TO_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  altr_hps_rr_arb2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            gnt1_q, gnt1_d;
  logic            gnt2_q, gnt2_d;
  logic            last_q, last_d;
  logic            to_q, to_d;
  logic            win2;
  logic            to_hit;

  // Requestor 2 wins when it is alone, or on a tie when requestor 1 was last served.
  assign win2   = bus.req_in2 & (~bus.req_in1 | ~last_q);
  // Counter reads 2^TO_W-1 during the 2^TO_W-th grant cycle.
  assign to_hit = (TO_EN != 0) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      last_q  <= 1'b1;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      last_q  <= last_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt1_d  = gnt1_q;
    gnt2_d  = gnt2_q;
    last_d  = last_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_in1 | bus.req_in2) begin
          state_d = GRANT;
          gnt1_d  = ~win2;
          gnt2_d  = win2;
          last_d  = win2;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // done_in takes priority over a timeout in the same cycle.
        if (bus.done_in) begin
          state_d = RELEASE;
          gnt1_d  = 1'b0;
          gnt2_d  = 1'b0;
        end else if (to_hit) begin
          state_d = RELEASE;
          gnt1_d  = 1'b0;
          gnt2_d  = 1'b0;
          to_d    = 1'b1;
        end else if (TO_EN != 0 && cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_out1    = gnt1_q;
  assign bus.gnt_out2    = gnt2_q;
  assign bus.busy_out    = (state_q != IDLE);
  assign bus.last_out    = last_q;
  assign bus.timeout_out = to_q;

endmodule

// File: tb/tb_altr_hps_rr_arb2.sv
// tb_altr_hps_rr_arb2 -- self-checking bench for altr_hps_rr_arb2.
// Two instances share one stimulus: dut_a (TO_W=4, timeout enabled) and
// dut_b (TO_W=4, timeout disabled). A transaction-level model tracks the
// current owner, how many cycles the grant has been held and the last winner.
module tb_altr_hps_rr_arb2;
  localparam int TW   = 4;
  localparam int TMAX = 1 << TW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r1 = 1'b0, r2 = 1'b0, dn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  altr_hps_rr_arb2_if ifa ();
  altr_hps_rr_arb2_if ifb ();
  assign ifa.req_in1 = r1;
  assign ifa.req_in2 = r2;
  assign ifa.done_in = dn;
  assign ifb.req_in1 = r1;
  assign ifb.req_in2 = r2;
  assign ifb.done_in = dn;

  altr_hps_rr_arb2 #(.TO_W(TW), .TO_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  altr_hps_rr_arb2 #(.TO_W(TW), .TO_EN(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  // Model: owner 0 = nobody, 1/2 = requestor; last 1/2 = last winner.
  int m_own[2], m_held[2], m_last[2];
  bit m_rel[2], m_to[2];

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i] = 0; m_held[i] = 0; m_last[i] = 2; m_rel[i] = 0; m_to[i] = 0;
    end
  endfunction

  function automatic void m_step(int i, bit en);
    m_to[i] = 0;
    if (m_rel[i]) m_rel[i] = 0;
    else if (m_own[i] != 0) begin
      m_held[i]++;
      if (dn) begin
        m_own[i] = 0; m_rel[i] = 1;
      end else if (en && m_held[i] == TMAX) begin
        m_own[i] = 0; m_rel[i] = 1; m_to[i] = 1;
      end
    end else if (r1 || r2) begin
      m_own[i]  = (r1 && r2) ? 3 - m_last[i] : (r1 ? 1 : 2);
      m_last[i] = m_own[i];
      m_held[i] = 0;
    end
  endfunction

  // {gnt1, gnt2, busy, last, timeout}
  function automatic logic [4:0] m_exp(int i);
    return {m_own[i] == 1, m_own[i] == 2, (m_own[i] != 0) || m_rel[i], m_last[i] == 2, m_to[i]};
  endfunction

  function automatic logic [4:0] obs(int i);
    if (i == 0) return {ifa.gnt_out1, ifa.gnt_out2, ifa.busy_out, ifa.last_out, ifa.timeout_out};
    return {ifb.gnt_out1, ifb.gnt_out2, ifb.busy_out, ifb.last_out, ifb.timeout_out};
  endfunction

  // One clock: model advances at the edge, outputs settle by the falling edge.
  task automatic step();
    @(posedge clk);
    m_step(0, 1'b1);
    m_step(1, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; r1 = 0; r2 = 0; dn = 0;
    @(negedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; r1 = 1; r2 = 1; dn = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs(i) !== 5'b00010) begin
        n_err++;
        $display("FAIL reset_state dut%0d got %b exp %b", i, obs(i), 5'b00010);
      end
    end
  endtask

  task automatic test_tie_after_reset();
    logic [4:0] seq_exp [5];
    do_reset();
    r1 = 1; r2 = 1;
    seq_exp[0] = 5'b10100;  // first tie goes to requestor 1
    seq_exp[1] = 5'b10100;
    seq_exp[2] = 5'b10100;
    seq_exp[3] = 5'b00100;  // release after done
    seq_exp[4] = 5'b00000;  // idle
    for (int k = 0; k < 5; k++) begin
      step();
      dn = (k == 2);
      n_vec++;
      if (obs(0) !== seq_exp[k] || obs(0) !== m_exp(0)) begin
        n_err++;
        $display("FAIL tie_seq cyc%0d got %b exp %b model %b", k, obs(0), seq_exp[k], m_exp(0));
      end
    end
    step();
    n_vec++;
    if (obs(0) !== 5'b01110) begin
      n_err++;
      $display("FAIL tie_second_grant got %b exp %b", obs(0), 5'b01110);
    end
  endtask

  task automatic test_single();
    int g = 0, b = 0, t = 0;
    do_reset();
    r2 = 1;
    for (int k = 0; k < 12; k++) begin
      step();
      n_vec++;
      if (obs(0) !== m_exp(0)) begin
        n_err++;
        $display("FAIL single_cyc%0d got %b exp %b", k, obs(0), m_exp(0));
      end
      if (ifa.gnt_out2) begin g++; r2 = 0; end
      if (ifa.busy_out) b++;
      if (ifa.timeout_out) t++;
      dn = ifa.gnt_out2 && (g == 4);
    end
    dn = 0;
    n_vec++;
    if (g != 4 || b != 5 || t != 0) begin
      n_err++;
      $display("FAIL single_counts got gnt=%0d busy=%0d to=%0d exp 4 5 0", g, b, t);
    end
  endtask

  task automatic test_timeout();
    int g = 0, wait_cyc = 0;
    do_reset();
    r1 = 1;
    step();
    while (ifa.gnt_out1 && wait_cyc < 100) begin
      g++;
      n_vec++;
      if (ifa.timeout_out !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_early cyc%0d got %b exp 0", g, ifa.timeout_out);
      end
      step();
      wait_cyc++;
    end
    r1 = 0;
    n_vec++;
    if (g != TMAX || obs(0) !== 5'b00101) begin
      n_err++;
      $display("FAIL timeout_fall got gnt_cycles=%0d out=%b exp %0d %b", g, obs(0), TMAX, 5'b00101);
    end
    step();
    n_vec++;
    if (obs(0) !== 5'b00000 || obs(0) !== m_exp(0)) begin
      n_err++;
      $display("FAIL timeout_idle got %b exp %b", obs(0), 5'b00000);
    end
  endtask

  task automatic test_boundary();
    int g = 0;
    do_reset();
    r1 = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ifa.gnt_out1) begin g++; r1 = 0; end
      n_vec++;
      if (obs(0) !== m_exp(0) || ifa.timeout_out !== 1'b0) begin
        n_err++;
        $display("FAIL boundary_cyc%0d got %b exp %b", k, obs(0), m_exp(0));
      end
      dn = ifa.gnt_out1 && (g == TMAX);
    end
    dn = 0;
    n_vec++;
    if (g != TMAX) begin
      n_err++;
      $display("FAIL boundary_len got %0d exp %0d", g, TMAX);
    end
  endtask

  task automatic test_disabled();
    int g = 0, t = 0;
    do_reset();
    r1 = 1;
    step();
    r1 = 0;
    for (int k = 0; k < 1000; k++) begin
      if (ifb.gnt_out1) g++;
      if (ifb.timeout_out) t++;
      step();
    end
    n_vec++;
    if (g != 1000 || t != 0 || obs(1) !== m_exp(1)) begin
      n_err++;
      $display("FAIL disabled_hold got gnt=%0d to=%0d out=%b exp 1000 0 %b", g, t, obs(1), m_exp(1));
    end
  endtask

  task automatic test_reset_mid_grant();
    int t = 0;
    do_reset();
    r1 = 1;
    repeat (3) step();
    n_vec++;
    if (ifa.gnt_out1 !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre got %b exp 1", ifa.gnt_out1);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs(i) !== 5'b00010) begin
        n_err++;
        $display("FAIL midrst_async dut%0d got %b exp %b", i, obs(i), 5'b00010);
      end
    end
    m_reset();
    r1 = 0;
    repeat (2) begin
      @(negedge clk);
      if (ifa.timeout_out) t++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dn = k[0];
      step();
      if (ifa.timeout_out) t++;
      n_vec++;
      if (obs(0) !== 5'b00010 || obs(1) !== 5'b00010) begin
        n_err++;
        $display("FAIL idle_done cyc%0d got %b/%b exp %b", k, obs(0), obs(1), 5'b00010);
      end
    end
    dn = 0;
    n_vec++;
    if (t != 0) begin
      n_err++;
      $display("FAIL midrst_timeout got %0d pulses exp 0", t);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (ifa.gnt_out1) r1 = 0; else if ($urandom_range(0, 3) == 0) r1 = 1;
      if (ifa.gnt_out2) r2 = 0; else if ($urandom_range(0, 3) == 0) r2 = 1;
      dn = (k < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (obs(i) !== m_exp(i)) begin
          n_err++;
          $display("FAIL random dut%0d cyc%0d got %b exp %b", i, k, obs(i), m_exp(i));
        end
      end
    end
    dn = 0; r1 = 0; r2 = 0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_tie_after_reset();
    test_single();
    test_timeout();
    test_boundary();
    test_disabled();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/altr_hps_rr_arb2.md
ALTR_HPS_RR_ARB2 -- requirements
Module: altr_hps_rr_arb2

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-002 Parameter TO_W SHALL default to 8 and set the width of the grant timeout counter (legal 2..16).
REQ-003 Parameter TO_EN SHALL default to 1; 1 enables the timeout, 0 disables it.
REQ-004 clk  input  1  block clock; all state is updated on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_in1  input  1  level request from requestor 1, held until served.
REQ-007 req_in2  input  1  level request from requestor 2, held until served.
REQ-008 done_in  input  1  single-cycle completion pulse from the shared resource.
REQ-009 gnt_out1  output  1  grant to requestor 1, registered.
REQ-010 gnt_out2  output  1  grant to requestor 2, registered.
REQ-011 busy_out  output  1  high whenever the state is not IDLE.
REQ-012 last_out  output  1  last-served requestor: 0 means requestor 1, 1 means requestor 2.
REQ-013 timeout_out  output  1  one-cycle pulse when a grant is released without done_in.

Function
REQ-014 The block SHALL implement three states: IDLE, GRANT and RELEASE.
REQ-015 IDLE: when req_in1 or req_in2 is high, the block SHALL enter GRANT on the next edge and assert exactly one grant from that edge.
REQ-016 Arbitration: a single request SHALL win outright.
REQ-017 Tie (both requests high): the requestor not indicated by last_out SHALL win.
REQ-018 last_out SHALL update to the winner on the same edge that the grant asserts.
REQ-019 Grant latency: a request sampled high in IDLE at edge N SHALL give a grant high from edge N+1.
REQ-020 At most one of gnt_out1 and gnt_out2 SHALL be high in any cycle.
REQ-021 GRANT: the grant SHALL stay high regardless of the requestor's req_in until done_in or timeout.
REQ-022 Counter: the counter SHALL clear to 0 on entry to GRANT.
REQ-023 Counter: the counter SHALL increment once per GRANT cycle and saturate at 2^TO_W-1.
REQ-024 done_in high in GRANT SHALL move the state to RELEASE on the next edge, with the grant low from that edge.
REQ-025 Timeout: with TO_EN=1, if the counter equals 2^TO_W-1 and done_in is low in GRANT, the block SHALL move to RELEASE.
REQ-026 On timeout, the grant SHALL drop and timeout_out SHALL pulse high for one cycle on the same edge.
REQ-027 On timeout, the grant SHALL therefore have been high for exactly 2^TO_W cycles.
REQ-028 Simultaneous done_in and timeout condition: done_in SHALL win, with no timeout_out pulse.
REQ-029 RELEASE SHALL last exactly one cycle, with no grant asserted, and then return to IDLE.
REQ-030 Back-to-back service: the earliest next grant SHALL be 3 edges after the done_in edge (one RELEASE cycle, then one IDLE cycle).
REQ-031 done_in SHALL be ignored in IDLE and RELEASE, with no state or output change.
REQ-032 With TO_EN=0, the timeout logic SHALL be inert: the counter is unused and timeout_out is held at 0.
REQ-033 busy_out SHALL be combinational from the state register only, with no input-to-output paths on any output.

Reset
REQ-034 While rst_n is low, the block SHALL hold IDLE, a zero counter, gnt_out1=0, gnt_out2=0, busy_out=0, last_out=1 and timeout_out=0.
REQ-035 Because last_out resets to 1, the first tie after reset SHALL go to requestor 1.
REQ-036 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously), and the aborted grant SHALL NOT produce a timeout_out pulse.
REQ-037 Reset release SHALL be synchronised externally; the block SHALL take its first transition on the first edge with rst_n high.

Verification
REQ-038 Tie after reset: both requests high at edge 1 -> gnt_out1=1 from edge 2 and last_out=0; done_in at edge 5 -> gnt_out1=0 at edge 6; both requests still high -> gnt_out2=1 at edge 8.
REQ-039 Single requestor: req_in2 only, done_in four cycles after the grant -> gnt_out2 high for exactly 4 cycles, busy_out high for 5 cycles, and timeout_out never asserts.
REQ-040 Timeout: TO_W=4, TO_EN=1, req_in1 held, done_in never asserted -> gnt_out1 high for 16 cycles, timeout_out=1 for one cycle on the edge the grant falls, then RELEASE and IDLE.
REQ-041 Boundary: TO_W=4, done_in asserted in the 16th grant cycle -> normal release and timeout_out stays 0.
REQ-042 Disabled timeout: TO_EN=0 with the grant held for 1000 cycles -> the grant stays high and timeout_out stays 0.
REQ-043 Reset mid-grant: rst_n low during GRANT -> all outputs reach their reset values without a clock edge, last_out=1, and no timeout_out pulse; stray done_in pulses in IDLE cause no change.
